// File: rtl/fp_serial_pkg.sv
// Shared types and width helpers for the serial floating-point add/subtract unit.
package fp_serial_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    ALIGN,
    ADD,
    NORM,
    ROUND,
    OUT
  } fsm_state_t;

  function automatic int fp_width(input int exp_w, input int man_w);
    return 1 + exp_w + man_w;
  endfunction

  function automatic int beat_count(input int exp_w, input int man_w, input int lanes);
    return fp_width(exp_w, man_w) / (lanes / 2);
  endfunction

  function automatic int beat_cnt_width(input int exp_w, input int man_w, input int lanes);
    int bw;
    bw = $clog2((2 * fp_width(exp_w, man_w)) / lanes);
    return (bw < 1) ? 1 : bw;
  endfunction

  // Canonical quiet NaN: sign 0, exponent all ones, mantissa MSB set.
  function automatic logic [127:0] qnan_bits(input int exp_w, input int man_w);
    logic [127:0] v;
    v = '0;
    for (int unsigned i = 0; i < 128; i++) begin
      if ((int'(i) + 1 >= man_w) && (int'(i) < man_w + exp_w)) v[i] = 1'b1;
    end
    return v;
  endfunction

endpackage

// File: rtl/fp_serial_addsub_if.sv
// Serial load / unload signal bundle for fp_serial_addsub.
interface fp_serial_addsub_if #(
  parameter int LANES = 4
);
  logic [LANES-1:0] serial_in;
  logic             wr_in;
  logic             op_in;
  logic             shift_out_in;
  logic             input_rdy;
  logic             output_rdy;
  logic             serial_out;
  logic             overflow_out;
  logic             zero_out;

  modport master (
    output serial_in, wr_in, op_in, shift_out_in,
    input  input_rdy, output_rdy, serial_out, overflow_out, zero_out
  );

  modport slave (
    input  serial_in, wr_in, op_in, shift_out_in,
    output input_rdy, output_rdy, serial_out, overflow_out, zero_out
  );
endinterface

// File: rtl/fp_addsub_core.sv
// ALIGN/ADD/NORM/ROUND datapath; each stage register loads when its enable is high,
// and the rounded result is combinational from the NORM registers during ROUND.
module fp_addsub_core
  import fp_serial_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   align_en,
  input  logic                   add_en,
  input  logic                   norm_en,
  input  logic                   op,
  input  logic [EXP_W+MAN_W:0]   a,
  input  logic [EXP_W+MAN_W:0]   b,
  output logic [EXP_W+MAN_W:0]   result,
  output logic                   overflow,
  output logic                   zero
);
  localparam int W     = fp_width(EXP_W, MAN_W);
  localparam int SIG_W = MAN_W + 4;
  localparam int EW    = EXP_W + 2;
  localparam int LZ_W  = $clog2(SIG_W + 1);

  localparam logic [EXP_W-1:0]    EXP_ONES  = '1;
  localparam logic [127:0]        QNAN_WIDE = qnan_bits(EXP_W, MAN_W);
  localparam logic [W-1:0]        QNAN      = QNAN_WIDE[W-1:0];
  localparam logic signed [EW-1:0] E_ONE    = 1;
  localparam logic signed [EW-1:0] E_ZERO   = 0;
  localparam logic signed [EW-1:0] E_MAX    = {2'b00, EXP_ONES};

  // Unpack
  logic             sa, sb, sb_eff;
  logic [EXP_W-1:0] ea, eb;
  logic [MAN_W-1:0] ma, mb, mant_a, mant_b;
  logic             a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;

  assign {sa, ea, ma} = a;
  assign {sb, eb, mb} = b;
  assign sb_eff = sb ^ op;
  assign a_zero = (ea == '0);
  assign b_zero = (eb == '0);
  assign a_inf  = (ea == EXP_ONES) && (ma == '0);
  assign b_inf  = (eb == EXP_ONES) && (mb == '0);
  assign a_nan  = (ea == EXP_ONES) && (ma != '0);
  assign b_nan  = (eb == EXP_ONES) && (mb != '0);
  assign mant_a = a_zero ? '0 : ma;
  assign mant_b = b_zero ? '0 : mb;

  // ALIGN
  logic                 swap, s_big, s_small;
  logic [EXP_W-1:0]     e_big, e_small, diff;
  logic [SIG_W-1:0]     sig_a, sig_b, sig_big, sig_small, aligned;
  logic [2*SIG_W-1:0]   wide;
  logic                 spec;
  logic [W-1:0]         spec_val;

  assign sig_a = {~a_zero, mant_a, 3'b000};
  assign sig_b = {~b_zero, mant_b, 3'b000};
  assign swap  = {eb, mant_b} > {ea, mant_a};

  always_comb begin
    s_big     = swap ? sb_eff : sa;
    s_small   = swap ? sa : sb_eff;
    e_big     = swap ? eb : ea;
    e_small   = swap ? ea : eb;
    sig_big   = swap ? sig_b : sig_a;
    sig_small = swap ? sig_a : sig_b;
    diff      = e_big - e_small;
    wide      = {sig_small, {SIG_W{1'b0}}} >> diff;
    if (int'(diff) >= MAN_W + 3)
      aligned = {{(SIG_W-1){1'b0}}, |sig_small};
    else
      aligned = {wide[2*SIG_W-1:SIG_W+1], wide[SIG_W] | (|wide[SIG_W-1:0])};
  end

  always_comb begin
    spec     = a_nan | b_nan | a_inf | b_inf;
    spec_val = QNAN;
    if (a_nan || b_nan)     spec_val = QNAN;
    else if (a_inf && b_inf) spec_val = (sa != sb_eff) ? QNAN : {sa, EXP_ONES, {MAN_W{1'b0}}};
    else if (a_inf)          spec_val = {sa, EXP_ONES, {MAN_W{1'b0}}};
    else if (b_inf)          spec_val = {sb_eff, EXP_ONES, {MAN_W{1'b0}}};
  end

  // Stage registers. Only one transaction is in flight, so ALIGN-stage sign,
  // exponent and special-case values are reused directly by later stages.
  logic                  r1_sign, r1_sub, r1_spec;
  logic [EXP_W-1:0]      r1_exp;
  logic [SIG_W-1:0]      r1_big, r1_small;
  logic [W-1:0]          r1_spec_val;
  logic [SIG_W:0]        r2_sum;
  logic [SIG_W-1:0]      r3_m;
  logic signed [EW-1:0]  r3_exp;
  logic                  r3_zero;

  // ADD
  logic [SIG_W:0] add_sum;
  assign add_sum = r1_sub ? ({1'b0, r1_big} - {1'b0, r1_small})
                          : ({1'b0, r1_big} + {1'b0, r1_small});

  // NORM
  logic [LZ_W-1:0]      lz;
  logic [SIG_W-1:0]     norm_m;
  logic signed [EW-1:0] exp_ext, norm_exp;
  logic                 norm_zero;

  always_comb begin
    lz = LZ_W'(SIG_W);
    for (int unsigned i = 0; i < SIG_W; i++) begin
      if (r2_sum[i]) lz = LZ_W'(SIG_W - 1 - i);
    end
    exp_ext   = $signed({2'b00, r1_exp});
    norm_zero = (r2_sum == '0);
    if (r2_sum[SIG_W]) begin
      norm_m   = {r2_sum[SIG_W:2], r2_sum[1] | r2_sum[0]};
      norm_exp = exp_ext + E_ONE;
    end else begin
      norm_m   = r2_sum[SIG_W-1:0] << lz;
      norm_exp = exp_ext - $signed({{(EW-LZ_W){1'b0}}, lz});
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r1_sign     <= 1'b0;
      r1_sub      <= 1'b0;
      r1_spec     <= 1'b0;
      r1_exp      <= '0;
      r1_big      <= '0;
      r1_small    <= '0;
      r1_spec_val <= '0;
      r2_sum      <= '0;
      r3_m        <= '0;
      r3_exp      <= '0;
      r3_zero     <= 1'b0;
    end else begin
      if (align_en) begin
        r1_sign     <= s_big;
        r1_sub      <= s_big ^ s_small;
        r1_spec     <= spec;
        r1_exp      <= e_big;
        r1_big      <= sig_big;
        r1_small    <= aligned;
        r1_spec_val <= spec_val;
      end
      if (add_en) r2_sum <= add_sum;
      if (norm_en) begin
        r3_m    <= norm_m;
        r3_exp  <= norm_exp;
        r3_zero <= norm_zero;
      end
    end
  end

  // ROUND: nearest-even on guard/round/sticky, renormalise on mantissa carry.
  logic                 round_up;
  logic [MAN_W+1:0]     rnd;
  logic [MAN_W-1:0]     frac;
  logic signed [EW-1:0] exp_r;

  always_comb begin
    round_up = r3_m[2] & (r3_m[1] | r3_m[0] | r3_m[3]);
    rnd      = {1'b0, r3_m[SIG_W-1:3]} + {{(MAN_W+1){1'b0}}, round_up};
    frac     = rnd[MAN_W+1] ? rnd[MAN_W:1] : rnd[MAN_W-1:0];
    exp_r    = r3_exp + (rnd[MAN_W+1] ? E_ONE : E_ZERO);

    result   = {r1_sign, exp_r[EXP_W-1:0], frac};
    overflow = 1'b0;
    zero     = 1'b0;
    if (r1_spec) begin
      result = r1_spec_val;
    end else if (r3_zero) begin
      result = '0;
      zero   = 1'b1;
    end else if (exp_r >= E_MAX) begin
      result   = {r1_sign, EXP_ONES, {MAN_W{1'b0}}};
      overflow = 1'b1;
    end else if (exp_r <= E_ZERO) begin
      result = {r1_sign, {(W-1){1'b0}}};
      zero   = 1'b1;
    end
  end

endmodule

// File: rtl/fp_serial_addsub.sv
// Serial-I/O floating-point add/subtract: lane deserialiser, control FSM,
// result shift register and status flags around fp_addsub_core.
module fp_serial_addsub
  import fp_serial_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int LANES = 4
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  fp_serial_addsub_if.slave bus
);
  localparam int W     = fp_width(EXP_W, MAN_W);
  localparam int LH    = LANES / 2;
  localparam int BEATS = beat_count(EXP_W, MAN_W, LANES);
  localparam int BC_W  = beat_cnt_width(EXP_W, MAN_W, LANES);
  localparam int SC_W  = (W > 1) ? $clog2(W) : 1;

  fsm_state_t       state_q, state_d;
  logic [BC_W-1:0]  beat_cnt;
  logic [SC_W-1:0]  shift_cnt;
  logic [W-1:0]     a_sr, b_sr, res_sr;
  logic             op_r, overflow_r, zero_r;
  logic             last_beat, last_shift, accept_beat, accept_shift;
  logic [W-1:0]     core_result;
  logic             core_overflow, core_zero;

  assign bus.input_rdy    = (state_q == IDLE) || (state_q == LOAD);
  assign bus.output_rdy   = (state_q == OUT);
  assign bus.serial_out   = res_sr[W-1];
  assign bus.overflow_out = overflow_r;
  assign bus.zero_out     = zero_r;

  assign last_beat    = (beat_cnt == BC_W'(BEATS - 1));
  assign last_shift   = (shift_cnt == SC_W'(W - 1));
  assign accept_beat  = bus.input_rdy && bus.wr_in;
  assign accept_shift = (state_q == OUT) && bus.shift_out_in;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.wr_in) state_d = last_beat ? ALIGN : LOAD;
      LOAD:    if (bus.wr_in && last_beat) state_d = ALIGN;
      ALIGN:   state_d = ADD;
      ADD:     state_d = NORM;
      NORM:    state_d = ROUND;
      ROUND:   state_d = OUT;
      OUT:     if (bus.shift_out_in && last_shift) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      beat_cnt   <= '0;
      shift_cnt  <= '0;
      a_sr       <= '0;
      b_sr       <= '0;
      res_sr     <= '0;
      op_r       <= 1'b0;
      overflow_r <= 1'b0;
      zero_r     <= 1'b0;
    end else begin
      if (accept_beat) begin
        a_sr     <= {a_sr[W-LH-1:0], bus.serial_in[LH-1:0]};
        b_sr     <= {b_sr[W-LH-1:0], bus.serial_in[LANES-1:LH]};
        beat_cnt <= last_beat ? '0 : beat_cnt + BC_W'(1);
        if (state_q == IDLE) op_r <= bus.op_in;
      end
      if (state_q == ROUND) begin
        res_sr     <= core_result;
        overflow_r <= core_overflow;
        zero_r     <= core_zero;
        shift_cnt  <= '0;
      end
      if (accept_shift) begin
        res_sr    <= {res_sr[W-2:0], 1'b0};
        shift_cnt <= shift_cnt + SC_W'(1);
        if (last_shift) begin
          overflow_r <= 1'b0;
          zero_r     <= 1'b0;
        end
      end
    end
  end

  fp_addsub_core #(
    .EXP_W (EXP_W),
    .MAN_W (MAN_W)
  ) u_core (
    .clk      (wb_clk_i),
    .rst      (wb_rst_i),
    .align_en (state_q == ALIGN),
    .add_en   (state_q == ADD),
    .norm_en  (state_q == NORM),
    .op       (op_r),
    .a        (a_sr),
    .b        (b_sr),
    .result   (core_result),
    .overflow (core_overflow),
    .zero     (core_zero)
  );

endmodule

// File: tb/tb_fp_serial_addsub.sv
// Directed-vector bench for fp_serial_addsub in the default 32-bit, 4-lane format.
module tb_fp_serial_addsub;

  logic wb_clk_i = 1'b0;
  logic wb_rst_i;

  always #5 wb_clk_i = ~wb_clk_i;

  fp_serial_addsub_if #(.LANES(4)) bus ();

  fp_serial_addsub #(
    .EXP_W (8),
    .MAN_W (23),
    .LANES (4)
  ) dut (
    .wb_clk_i (wb_clk_i),
    .wb_rst_i (wb_rst_i),
    .bus      (bus)
  );

  int errors = 0;
  int checks = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] out_vec();
    return {27'b0, bus.input_rdy, bus.output_rdy, bus.serial_out, bus.overflow_out, bus.zero_out};
  endfunction

  // Entry and exit point of every task: 1 time unit after a rising edge.
  task automatic load(input logic [31:0] a, input logic [31:0] b, input logic op,
                      input int nbeats, input bit gaps);
    for (int i = 0; i < nbeats; i++) begin
      if (gaps) begin
        bus.wr_in = 1'b0;
        repeat ($urandom_range(0, 2)) begin
          @(posedge wb_clk_i); #1;
        end
      end
      bus.wr_in     = 1'b1;
      bus.op_in     = (i == 0) ? op : ~op;
      bus.serial_in = {b[31-2*i], b[30-2*i], a[31-2*i], a[30-2*i]};
      @(posedge wb_clk_i); #1;
      bus.wr_in = 1'b0;
    end
  endtask

  task automatic wait_out(input string tag);
    int n;
    n = 0;
    while (!bus.output_rdy && n < 20) begin
      @(posedge wb_clk_i); #1;
      n++;
    end
    check_eq({tag, " latency"}, n, 4);
  endtask

  task automatic run(input string tag, input logic [31:0] a, input logic [31:0] b,
                     input logic op, input logic [31:0] exp_res, input logic [1:0] exp_fl,
                     input bit gaps);
    logic [31:0] res;
    int          k;
    int          flag_bad;
    load(a, b, op, 16, gaps);
    check_eq({tag, " in_rdy"}, {31'b0, bus.input_rdy}, 32'd0);
    wait_out(tag);
    check_eq({tag, " flags"}, {30'b0, bus.overflow_out, bus.zero_out}, {30'b0, exp_fl});
    res      = '0;
    flag_bad = 0;
    for (int i = 31; i >= 0; i--) begin
      if (gaps) begin
        k = int'($urandom_range(0, 3));
        bus.wr_in     = 1'b1;
        bus.serial_in = 4'hF;
        repeat (k) begin
          @(posedge wb_clk_i); #1;
        end
        bus.wr_in = 1'b0;
        if (k > 0) check_eq({tag, " hold"}, {31'b0, bus.serial_out}, {31'b0, exp_res[i]});
      end
      res[i] = bus.serial_out;
      if ({bus.overflow_out, bus.zero_out} !== exp_fl) flag_bad++;
      bus.shift_out_in = 1'b1;
      @(posedge wb_clk_i); #1;
      bus.shift_out_in = 1'b0;
    end
    check_eq({tag, " result"}, res, exp_res);
    check_eq({tag, " flag_stable"}, flag_bad, 0);
    check_eq({tag, " done_rdy"}, {30'b0, bus.output_rdy, bus.input_rdy}, 32'd1);
  endtask

  task automatic pulse_reset(input string tag);
    wb_rst_i = 1'b1;
    #1;
    check_eq({tag, " reset_outs"}, out_vec(), 32'h10);
    @(posedge wb_clk_i); #1;
    wb_rst_i = 1'b0;
    @(posedge wb_clk_i); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bus.serial_in    = '0;
    bus.wr_in        = 1'b0;
    bus.op_in        = 1'b0;
    bus.shift_out_in = 1'b0;
    wb_rst_i         = 1'b1;
    @(posedge wb_clk_i); #1;
    check_eq("por reset_outs", out_vec(), 32'h10);
    wb_rst_i = 1'b0;
    @(posedge wb_clk_i); #1;

    run("add_1_2",   32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 2'b00, 1'b0);
    run("sub_cancel", 32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 2'b01, 1'b1);
    run("tie_even",  32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 2'b00, 1'b0);
    run("tie_odd",   32'h3F800001, 32'h33800000, 1'b0, 32'h3F800002, 2'b00, 1'b0);
    run("overflow",  32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 2'b10, 1'b0);
    run("inf_m_inf", 32'h7F800000, 32'hFF800000, 1'b0, 32'h7FC00000, 2'b00, 1'b0);
    run("nan_in",    32'h7FC00001, 32'h3F800000, 1'b0, 32'h7FC00000, 2'b00, 1'b0);
    run("sub_gaps",  32'h40000000, 32'h3F800000, 1'b1, 32'h3F800000, 2'b00, 1'b1);

    load(32'h12345678, 32'h9ABCDEF0, 1'b0, 7, 1'b0);
    pulse_reset("rst_load");
    run("after_rst_load", 32'h40000000, 32'h3F800000, 1'b1, 32'h3F800000, 2'b00, 1'b0);

    load(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 16, 1'b0);
    wait_out("rst_out");
    for (int i = 0; i < 5; i++) begin
      bus.shift_out_in = 1'b1;
      @(posedge wb_clk_i); #1;
      bus.shift_out_in = 1'b0;
    end
    pulse_reset("rst_out");
    run("after_rst_out", 32'h40000000, 32'h3F800000, 1'b1, 32'h3F800000, 2'b00, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
